md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle multiply/divide sequencer and HI/LO owner for the pipelined MIPS core.
//  - Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage.
//  - Counts out a fixed latency, then commits the result to HI/LO.
//  - Raises a stall request so the decoder/hazard logic holds the next HI/LO-touching instruction in D.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-low reset
//  md_start  in   1   E-stage instruction is a MD op this cycle (already gated by E valid)
//  md_op     in   3   `MdMult/`MdMultu/`MdDiv/`MdDivu/`MdMthi/`MdMtlo
//  md_a      in   32  forwarded rs value
//  md_b      in   32  forwarded rt value
//  d_is_md   in   1   D-stage instr uses HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
//  md_hi     out  32  architectural HI (feeds MFHI path)
//  md_lo     out  32  architectural LO (feeds MFLO path)
//  md_busy   out  1   operation in flight (registered)
//  md_stall  out  1   combinational: d_is_md & (md_busy | start_mul_div)
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, cnt=0, md_hi=md_lo=0, md_busy=0; pending regs=0.
//  - States: IDLE, RUN.
//    * IDLE --(md_start & op in {MULT,MULTU,DIV,DIVU})--> RUN; cnt <= N.
//      N = MULT_CYCLES or DIV_CYCLES.
//    * RUN: cnt decrements each edge.
//      At the edge where cnt==1: md_hi/md_lo <= pending; state <= IDLE.
//  - Results are computed from md_a/md_b in the start cycle and latched into pend_hi/pend_lo.
//    Operands need not stay stable afterwards.
//  - Latency: start sampled at edge ending cycle T.
//    * md_busy is high for cycles T+1..T+N.
//    * New HI/LO are visible from cycle T+N+1.
//    * HI/LO hold their old values throughout RUN.
//  - start_mul_div = md_start & op in mul/div set & state==IDLE.
//  - MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
//  - DIV/DIVU:
//    * LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//    * DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//  - Divide by zero (md_b==0): full DIV_CYCLES busy period; HI/LO unchanged at commit.
//  - MTHI/MTLO (IDLE only):
//    * md_hi or md_lo <= md_a at the next edge.
//    * md_busy stays 0; no stall is generated by the op itself.
//  - md_start while RUN: ignored, no state change.
//    This is a hazard-logic bug; the bench flags it with an assertion.
//  - md_stall goes high in the start cycle when d_is_md is high, even though md_busy is still 0.
//  - md_stall drops in cycle T+N+1, the same cycle HI/LO are updated.
//  - Back-to-back: the next start is accepted in cycle T+N+1, and a new RUN begins at that edge.
//  - Reset mid-RUN aborts the operation; pending results are discarded and HI/LO=0.
// STRUCTURE
//  - settings.v gets the `MdMult..`MdMtlo op encodings (3 bits) and `MdNone=0.
//    The Control decoder drives md_op from Opcode/Funct using these.
//  - Sub-module md_result_calc (combinational): inputs op, a, b; outputs hi, lo, div0.
//    Keeps the arithmetic separate from the counter/FSM.
//  - Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
// TESTING
//  1. MULT a=0xFFFFFFFF, b=2
//     -> busy 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE at T+6.
//  2. MULTU a=0xFFFFFFFF, b=2
//     -> HI=0x00000001, LO=0xFFFFFFFE. With d_is_md=1 throughout, md_stall=1 T..T+5, then 0.
//  3. DIV a=-7 (0xFFFFFFF9), b=2
//     -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIVU same operands: LO=0x7FFFFFFC, HI=1.
//  4. DIV b=0 with prior HI=0x11, LO=0x22
//     -> busy 10 cycles; HI/LO stay 0x11/0x22.
//  5. MTHI a=0xDEADBEEF, then MTLO a=0x1234
//     -> md_hi/md_lo update on the next edges; md_busy never asserts.
//  6. reset=0 at cycle T+3 of a MULT
//     -> immediately md_busy=0, HI=LO=0; a fresh MULT after release completes normally.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: MD op encodings, FSM state type and op classification helper
package md_sequencer_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {IDLE, RUN} md_state_e;

  function automatic logic is_mul_div(input logic [2:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/md_result_calc.sv
// md_result_calc: combinational HI/LO result for MULT/MULTU/DIV/DIVU
//   op   in  3   md op encoding
//   a,b  in  32  rs / rt operands
//   hi   out 32  product high word / remainder
//   lo   out 32  product low word / quotient
//   div0 out 1   divide op with zero divisor
module md_result_calc
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);
  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        ovf;
  logic [31:0] sdiv;
  logic [31:0] udiv;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'b0, a} * {32'b0, b};
  // Zero divisors and MIN/-1 are steered to a divisor of 1: MIN/1 yields the
  // architecturally required LO=0x80000000, HI=0, and no divide ever traps.
  assign ovf  = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign sdiv = (b == 32'd0 || ovf) ? 32'd1 : b;
  assign udiv = b == 32'd0 ? 32'd1 : b;
  assign sq   = $signed(a) / $signed(sdiv);
  assign sr   = $signed(a) % $signed(sdiv);
  assign uq   = a / udiv;
  assign ur   = a % udiv;
  assign div0 = (op == MD_DIV || op == MD_DIVU) && b == 32'd0;
  always_comb begin
    hi = op == MD_MULT ? sprod[63:32] : op == MD_MULTU ? uprod[63:32] : op == MD_DIV ? sr : ur;
    lo = op == MD_MULT ? sprod[31:0]  : op == MD_MULTU ? uprod[31:0]  : op == MD_DIV ? sq : uq;
  end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mul/div sequencer owning architectural HI/LO
//   clk, reset(async, active-low)
//   md_start/md_op/md_a/md_b  E-stage MD op and operands
//   d_is_md                   D-stage instruction touches HI/LO
//   md_hi/md_lo               architectural HI/LO
//   md_busy                   op in flight (registered)
//   md_stall                  hold D-stage HI/LO user
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        d_is_md,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo,
  output logic        md_busy,
  output logic        md_stall
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   state;
  md_state_e   state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_div0;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_div0;
  logic        start_mul_div;
  logic        commit;
  logic        idle_start;

  md_result_calc u_calc (
    .op  (md_op),
    .a   (md_a),
    .b   (md_b),
    .hi  (r_hi),
    .lo  (r_lo),
    .div0(r_div0)
  );

  assign idle_start    = md_start && state == IDLE;
  assign start_mul_div = idle_start && is_mul_div(md_op);
  assign commit        = state == RUN && cnt == CW'(1);
  assign md_busy       = state == RUN;
  assign md_stall      = d_is_md && (md_busy || start_mul_div);

  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start_mul_div ? RUN : IDLE) : (commit ? IDLE : RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_div0 <= 1'b0;
      md_hi     <= '0;
      md_lo     <= '0;
    end else begin
      if (start_mul_div) begin
        cnt       <= (md_op == MD_MULT || md_op == MD_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        pend_hi   <= r_hi;
        pend_lo   <= r_lo;
        pend_div0 <= r_div0;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (commit && !pend_div0) begin
        md_hi <= pend_hi;
        md_lo <= pend_lo;
      end
      if (idle_start && md_op == MD_MTHI) md_hi <= md_a;
      if (idle_start && md_op == MD_MTLO) md_lo <= md_a;
    end
  end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed + random check of md_sequencer against a behavioural model
module tb_md_sequencer;
  import md_sequencer_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        md_start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] md_a = '0;
  logic [31:0] md_b = '0;
  logic        d_is_md = 1'b0;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_busy;
  logic        md_stall;

  int n_checks = 0;
  int n_fail = 0;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .md_start(md_start),
    .md_op   (md_op),
    .md_a    (md_a),
    .md_b    (md_b),
    .d_is_md (d_is_md),
    .md_hi   (md_hi),
    .md_lo   (md_lo),
    .md_busy (md_busy),
    .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // Architectural reference: arithmetic done in 64 bits straight from the op definitions.
  function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op == MD_MULT) begin
      p = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == MD_MULTU) begin
      p = ua * ub;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
    end else if (op == MD_DIV) begin
      q = sa / sb;
      r = sa - q * sb;
      hi = r[31:0];
      lo = q[31:0];
    end else begin
      p = ua / ub;
      hi = 32'(ua - p * ub);
      lo = p[31:0];
    end
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_dz;
  int          m_left;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = '0;
      m_lo = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !p_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (md_start) begin
      if (md_op >= MD_MULT && md_op <= MD_DIVU) begin
        ref_calc(md_op, md_a, md_b, p_hi, p_lo, p_dz);
        m_left = (md_op <= MD_MULTU) ? MC : DC;
      end else if (md_op == MD_MTHI) m_hi = md_a;
      else if (md_op == MD_MTLO) m_lo = md_a;
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = d_is_md && (m_left > 0 || (md_start && md_op >= MD_MULT && md_op <= MD_DIVU));
    chk("hi", md_hi, m_hi);
    chk("lo", md_lo, m_lo);
    chk("busy", 32'(md_busy), 32'(m_left > 0));
    chk("stall", 32'(md_stall), 32'(exp_stall));
    chk("hazard_start_while_busy", 32'(md_start && md_busy), 32'd0);
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    @(posedge clk); #1;
    md_start = 1'b1;
    md_op = op;
    md_a = a;
    md_b = b;
    @(posedge clk); #1;
    md_start = 1'b0;
    md_a = $urandom;
    md_b = $urandom;
    if (op <= MD_MULTU) repeat (MC) @(posedge clk);
    else if (op <= MD_DIVU) repeat (DC) @(posedge clk);
    @(negedge clk);
    chk({name, "_hi"}, md_hi, ehi);
    chk({name, "_lo"}, md_lo, elo);
  endtask

  initial begin
    #1;
    chk("rst_hi", md_hi, 32'd0);
    chk("rst_lo", md_lo, 32'd0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    #20 reset = 1'b1;
    run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    d_is_md = 1'b1;
    md_start = 1'b1;
    md_op = MD_MULTU;
    md_a = 32'hFFFF_FFFF;
    md_b = 32'd2;
    @(negedge clk);
    chk("multu_stall_start", 32'(md_stall), 32'd1);
    chk("multu_busy_start", 32'(md_busy), 32'd0);
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (MC) @(posedge clk);
    @(negedge clk);
    chk("multu_hi", md_hi, 32'h0000_0001);
    chk("multu_lo", md_lo, 32'hFFFF_FFFE);
    chk("multu_stall_drop", 32'(md_stall), 32'd0);
    d_is_md = 1'b0;
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("mthi11", MD_MTHI, 32'h11, 32'd0, 32'h11, 32'h7FFF_FFFC);
    run_op("mtlo22", MD_MTLO, 32'h22, 32'd0, 32'h11, 32'h22);
    run_op("div0", MD_DIV, 32'h1234_5678, 32'd0, 32'h11, 32'h22);
    run_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("mthi", MD_MTHI, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'h8000_0000);
    run_op("mtlo", MD_MTLO, 32'h1234, 32'd0, 32'hDEAD_BEEF, 32'h1234);
    @(posedge clk); #1;
    md_start = 1'b1;
    md_op = MD_MULT;
    md_a = 32'd7;
    md_b = 32'd9;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(md_busy), 32'd0);
    chk("midrst_hi", md_hi, 32'd0);
    chk("midrst_lo", md_lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_op("fresh", MD_MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      d_is_md = 1'($urandom);
      md_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: md_b = 32'd0;
        1: begin md_a = 32'h8000_0000; md_b = 32'hFFFF_FFFF; end
        2: begin md_a = $urandom; md_b = 32'($urandom_range(1, 9)); end
        default: begin md_a = $urandom; md_b = $urandom; end
      endcase
      md_start = m_left == 0 && $urandom_range(0, 2) != 0;
    end
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (DC + 2) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
